// File: rtl/cic_pkg.sv
// Shared types and constants for the stereo PDM CIC decimator.
package cic_pkg;

  localparam int unsigned W_DEFAULT = 16;

  // pdm_din 0 maps to +1 and pdm_din 1 maps to -1; the user sign-extends these to W.
  localparam logic signed [1:0] PDM_ZERO = 2'sb01;
  localparam logic signed [1:0] PDM_ONE  = 2'sb11;

  typedef enum logic [2:0] {
    StIdle,
    StC1L,
    StC2L,
    StOutL,
    StC1R,
    StC2R,
    StOutR
  } cic_state_e;

endpackage

// File: rtl/cic_integrator_pair.sv
// Two cascaded CIC integrators for one channel. i2_o is the value i2 holds after this cycle's
// edge, so the caller can snapshot the post-update value during the enable cycle itself.
module cic_integrator_pair
  import cic_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] i2_o
);

  logic signed [W-1:0] i1_q;
  logic signed [W-1:0] i2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      i1_q <= '0;
      i2_q <= '0;
    end else if (en_i) begin
      i1_q <= i1_q + x_i;
      i2_q <= i2_q + i1_q;
    end
  end

  assign i2_o = en_i ? (i2_q + i1_q) : i2_q;

endmodule

// File: rtl/pdm_cic_sched.sv
// Stereo PDM front end: bit-clock divider, L/R demux, per-channel integrators and one
// time-shared comb subtractor feeding a channel-tagged valid/ready PCM stream.
module pdm_cic_sched
  import cic_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned DECIM   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pdm_din,
  output logic                pdm_clk,
  output logic signed [W-1:0] pcm_data,
  output logic                pcm_chan,
  output logic                pcm_valid,
  input  logic                pcm_ready,
  output logic                overrun
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned DW = $clog2(DECIM);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);

  logic [CW-1:0]       cnt_q;
  logic [DW-1:0]       dcnt_q;
  logic                pdm_clk_q;
  logic                wrap, strobe_l, strobe_r, frame;
  logic signed [W-1:0] x, i2_l, i2_r;
  logic signed [W-1:0] snap_l_q, snap_r_q, p1_l_q, p1_r_q, p2_l_q, p2_r_q, t_q;
  logic signed [W-1:0] sub_a, sub_b, diff;
  logic signed [W-1:0] pcm_data_q;
  logic                pcm_chan_q, pcm_valid_q, overrun_q;
  cic_state_e          state_q;

  // Left bit is valid just before pdm_clk falls, right bit just before it rises.
  assign wrap     = (cnt_q == CNT_LAST);
  assign strobe_l = wrap & pdm_clk_q;
  assign strobe_r = wrap & ~pdm_clk_q;
  assign frame    = strobe_r & (dcnt_q == DCNT_LAST);
  assign x        = pdm_din ? W'(PDM_ONE) : W'(PDM_ZERO);

  cic_integrator_pair #(.W(W)) u_int_l (
    .clk   (clk),
    .reset (reset),
    .en_i  (strobe_l),
    .x_i   (x),
    .i2_o  (i2_l)
  );

  cic_integrator_pair #(.W(W)) u_int_r (
    .clk   (clk),
    .reset (reset),
    .en_i  (strobe_r),
    .x_i   (x),
    .i2_o  (i2_r)
  );

  // The single comb subtractor; operands are steered by the scheduler state.
  always_comb begin
    sub_a = t_q;
    sub_b = p2_l_q;
    case (state_q)
      StC1L:   begin sub_a = snap_l_q; sub_b = p1_l_q; end
      StC2L:   begin sub_a = t_q;      sub_b = p2_l_q; end
      StC1R:   begin sub_a = snap_r_q; sub_b = p1_r_q; end
      StC2R:   begin sub_a = t_q;      sub_b = p2_r_q; end
      default: ;
    endcase
  end

  assign diff = sub_a - sub_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      pdm_clk_q   <= 1'b0;
      dcnt_q      <= '0;
      snap_l_q    <= '0;
      snap_r_q    <= '0;
      p1_l_q      <= '0;
      p1_r_q      <= '0;
      p2_l_q      <= '0;
      p2_r_q      <= '0;
      t_q         <= '0;
      pcm_data_q  <= '0;
      pcm_chan_q  <= 1'b0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= StIdle;
    end else begin
      overrun_q <= 1'b0;
      if (wrap) begin
        cnt_q     <= '0;
        pdm_clk_q <= ~pdm_clk_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (strobe_r) begin
        dcnt_q <= frame ? '0 : dcnt_q + DW'(1);
      end
      // A frame arriving while the comb is still busy is dropped whole.
      if (frame && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (frame) begin
            snap_l_q <= i2_l;
            snap_r_q <= i2_r;
            state_q  <= StC1L;
          end
        end
        StC1L: begin
          t_q     <= diff;
          p1_l_q  <= snap_l_q;
          state_q <= StC2L;
        end
        StC2L: begin
          pcm_data_q  <= diff;
          p2_l_q      <= t_q;
          pcm_chan_q  <= 1'b0;
          pcm_valid_q <= 1'b1;
          state_q     <= StOutL;
        end
        StOutL: begin
          if (pcm_ready) begin
            pcm_valid_q <= 1'b0;
            state_q     <= StC1R;
          end
        end
        StC1R: begin
          t_q     <= diff;
          p1_r_q  <= snap_r_q;
          state_q <= StC2R;
        end
        StC2R: begin
          pcm_data_q  <= diff;
          p2_r_q      <= t_q;
          pcm_chan_q  <= 1'b1;
          pcm_valid_q <= 1'b1;
          state_q     <= StOutR;
        end
        StOutR: begin
          if (pcm_ready) begin
            pcm_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pdm_clk   = pdm_clk_q;
  assign pcm_data  = pcm_data_q;
  assign pcm_chan  = pcm_chan_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_sched.sv
// Self-checking bench: a cycle-count model of the strobe schedule plus a closed-form CIC
// model (second difference of double-integrated input) scoreboards every PCM sample.
module tb_pdm_cic_sched;

  localparam int unsigned W       = 16;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DECIM   = 4;
  localparam int unsigned FRAME   = 2 * CLK_DIV * DECIM;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pdm_din = 1'b0;
  logic         pcm_ready = 1'b1;
  logic         pdm_clk;
  logic [W-1:0] pcm_data;
  logic         pcm_chan;
  logic         pcm_valid;
  logic         overrun;

  pdm_cic_sched #(.W(W), .CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .pdm_din   (pdm_din),
    .pdm_clk   (pdm_clk),
    .pcm_data  (pcm_data),
    .pcm_chan  (pcm_chan),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Cycle index since reset release: 0 is the first cycle with reset low.
  int cur_cyc = 0;
  always @(posedge clk) cur_cyc <= reset ? 0 : cur_cyc + 1;

  function automatic bit m_pdm_clk(input int c);
    return ((c / CLK_DIV) % 2) == 1;
  endfunction
  function automatic bit m_wrap(input int c);
    return (c % CLK_DIV) == (CLK_DIV - 1);
  endfunction
  function automatic bit m_left(input int c);
    return m_wrap(c) && m_pdm_clk(c);
  endfunction
  function automatic bit m_right(input int c);
    return m_wrap(c) && !m_pdm_clk(c);
  endfunction
  function automatic bit m_frame(input int c);
    return m_right(c) && (((c / (2 * CLK_DIV)) % DECIM) == DECIM - 1);
  endfunction

  // i2 after n inputs = sum over k of x[k] * (n-1-k), taken modulo 2^W.
  function automatic logic [W-1:0] integ2(input int q[$]);
    longint acc;
    acc = 0;
    for (int k = 0; k < q.size(); k++) acc += longint'(q[k]) * longint'(q.size() - 1 - k);
    return acc[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         chan;
  } samp_t;

  int           xl[$];
  int           xr[$];
  samp_t        expq[$];
  samp_t        s_item;
  logic [W-1:0] hl1, hl2, hr1, hr2, sl, sr;
  int           acc_frames, xfers, lat, since_lx, ovr_seen, c;
  bit           exp_ovr, ovr_next;
  logic [W-1:0] last_l, last_r;

  always @(negedge clk) begin
    if (reset) begin
      xl.delete();
      xr.delete();
      expq.delete();
      hl1 = '0; hl2 = '0; hr1 = '0; hr2 = '0;
      acc_frames = 0; xfers = 0; lat = -1; since_lx = -1;
      exp_ovr = 1'b0;
    end else begin
      c = cur_cyc;
      ovr_next = 1'b0;
      check("pdm_clk", W'(pdm_clk), W'(m_pdm_clk(c)));
      check("overrun", W'(overrun), W'(exp_ovr));
      if (overrun === 1'b1) ovr_seen++;
      if (c == 0) begin
        check("rst_data", pcm_data, '0);
        check("rst_chan", W'(pcm_chan), '0);
        check("rst_valid", W'(pcm_valid), '0);
      end
      if (lat == 1 || lat == 2) check("lat_early", W'(pcm_valid), '0);
      if (lat == 3) begin
        check("lat_left_valid", W'(pcm_valid), W'(1));
        check("lat_left_chan", W'(pcm_chan), '0);
      end
      if (since_lx == 1 || since_lx == 2) check("right_early", W'(pcm_valid), '0);
      if (since_lx == 3) begin
        check("right_valid", W'(pcm_valid), W'(1));
        check("right_chan", W'(pcm_chan), W'(1));
      end
      if (pcm_valid === 1'b1) begin
        if (expq.size() == 0) begin
          check("spurious_valid", W'(pcm_valid), '0);
        end else begin
          check("pcm_data", pcm_data, expq[0].data);
          check("pcm_chan", W'(pcm_chan), W'(expq[0].chan));
        end
      end
      if (m_left(c)) xl.push_back(pdm_din ? -1 : 1);
      if (m_right(c)) xr.push_back(pdm_din ? -1 : 1);
      if (m_frame(c)) begin
        if (xfers == 2 * acc_frames) begin
          sl = integ2(xl);
          sr = integ2(xr);
          s_item.data = sl - 2 * hl1 + hl2; s_item.chan = 1'b0; expq.push_back(s_item);
          s_item.data = sr - 2 * hr1 + hr2; s_item.chan = 1'b1; expq.push_back(s_item);
          hl2 = hl1; hl1 = sl; hr2 = hr1; hr1 = sr;
          acc_frames++;
          lat = 0;
        end else begin
          ovr_next = 1'b1;
        end
      end
      if (pcm_valid === 1'b1 && pcm_ready === 1'b1 && expq.size() > 0) begin
        if (expq[0].chan) last_r = pcm_data;
        else begin
          last_l = pcm_data;
          since_lx = 0;
        end
        void'(expq.pop_front());
        xfers++;
      end
      exp_ovr = ovr_next;
      lat = (lat >= 0 && lat < 3) ? lat + 1 : -1;
      since_lx = (since_lx >= 0 && since_lx < 3) ? since_lx + 1 : -1;
    end
  end

  // 0: all zeros, 1: left bits 0 / right bits 1, 2: random bits.
  int mode = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      1:       pdm_din = m_pdm_clk(cur_cyc) ? 1'b0 : 1'b1;
      2:       pdm_din = 1'($urandom_range(0, 1));
      default: pdm_din = 1'b0;
    endcase
  endtask

  task automatic wait_valid(input logic chan);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pcm_valid === 1'b1 && pcm_chan === chan) found = 1'b1;
      else tick();
    end
    check("wait_valid_timeout", W'(found), W'(1));
  endtask

  int ovr_base;

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Constant zero input: steady-state gain DECIM^2.
    repeat (FRAME * 8) tick();
    check("dc_left", last_l, W'(16));
    check("dc_right", last_r, W'(16));

    mode = 1;
    repeat (FRAME * 8) tick();
    check("split_left", last_l, W'(16));
    check("split_right", last_r, -W'(16));
    check("no_overrun_ab", W'(ovr_seen), '0);

    mode = 2;
    repeat (FRAME * 6) tick();

    // Backpressure on a left sample, released before the next frame.
    wait_valid(1'b1);
    tick();
    pcm_ready = 1'b0;
    wait_valid(1'b0);
    repeat (9) tick();
    pcm_ready = 1'b1;
    repeat (FRAME * 2) tick();
    check("no_overrun_bp", W'(ovr_seen), '0);

    // Backpressure held across a frame strobe: that frame is dropped.
    wait_valid(1'b1);
    tick();
    pcm_ready = 1'b0;
    wait_valid(1'b0);
    ovr_base = ovr_seen;
    repeat (20) tick();
    pcm_ready = 1'b1;
    repeat (FRAME * 3) tick();
    check("overrun_pulses", W'(ovr_seen - ovr_base), W'(1));

    // Reset while the left comb stage 2 is running.
    for (int i = 0; i < 2 * FRAME && !m_frame(cur_cyc); i++) tick();
    check("frame_found", W'(m_frame(cur_cyc)), W'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode = 0;
    repeat (FRAME * 6) tick();
    check("post_reset_left", last_l, W'(16));
    check("post_reset_right", last_r, W'(16));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
